// File: rtl/regfile_mp.sv
// Two-read/one-write register file with optional zero register, write bypass, post-reset clear and pending scoreboard.
// Reads are combinational and writes land on the next edge; there is no backpressure, but init_busy blocks all use during the clear.
module regfile_mp #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rd_pend1,
  output logic              rd_pend2,
  output logic              init_busy
);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  // A ZERO_REG outside the array disables the zero register entirely.
  localparam bit                ZERO_EN   = (ZERO_REG < NUM_REGS);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam bit                BYP_EN    = (BYPASS != 0);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_clr_ptr;
  logic [NUM_REGS-1:0] r_pend;
  logic [DATA_W-1:0]   r_mem [NUM_REGS];

  logic w_ready;
  logic w_wr_ok;
  logic w_rsv_ok;
  logic w_byp1;
  logic w_byp2;
  logic w_zero1;
  logic w_zero2;

  assign w_ready  = (r_state == ST_READY);
  assign w_wr_ok  = w_ready && wr_en && !(ZERO_EN && (wr_addr == ZERO_ADDR));
  assign w_rsv_ok = w_ready && rsv_en && !(ZERO_EN && (rsv_addr == ZERO_ADDR));
  assign w_byp1   = BYP_EN && wr_en && (wr_addr == rd_addr1);
  assign w_byp2   = BYP_EN && wr_en && (wr_addr == rd_addr2);
  assign w_zero1  = ZERO_EN && (rd_addr1 == ZERO_ADDR);
  assign w_zero2  = ZERO_EN && (rd_addr2 == ZERO_ADDR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
      r_pend    <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
      if (r_clr_ptr == LAST_ADDR) r_state <= ST_READY;
    end else begin
      // Set follows clear so a same-index reservation supersedes the retiring write.
      if (wr_en)    r_pend[wr_addr]  <= 1'b0;
      if (w_rsv_ok) r_pend[rsv_addr] <= 1'b1;
    end
  end

  // The array is left alone on reset edges; the clear sequence zeroes it afterwards.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == ST_CLEAR) r_mem[r_clr_ptr] <= '0;
      else if (w_wr_ok)        r_mem[wr_addr]   <= wr_data;
    end
  end

  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (w_ready && !w_zero1) rd_data1 = w_byp1 ? wr_data : r_mem[rd_addr1];
    if (w_ready && !w_zero2) rd_data2 = w_byp2 ? wr_data : r_mem[rd_addr2];
  end

  assign rd_pend1  = w_ready && r_pend[rd_addr1] && !w_byp1;
  assign rd_pend2  = w_ready && r_pend[rd_addr2] && !w_byp2;
  assign init_busy = !w_ready;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: bypassed and non-bypassed 32x64 instances share stimulus,
// plus a 16x32 instance with the zero register disabled.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr, rsv_addr;
  logic        wr_en, rsv_en;
  logic [63:0] wr_data;

  logic [63:0] b_rd_data1, b_rd_data2, n_rd_data1, n_rd_data2;
  logic        b_rd_pend1, b_rd_pend2, b_init_busy;
  logic        n_rd_pend1, n_rd_pend2, n_init_busy;

  logic [3:0]  s_rd_addr1, s_rd_addr2, s_wr_addr, s_rsv_addr;
  logic        s_wr_en, s_rsv_en;
  logic [31:0] s_wr_data, s_rd_data1, s_rd_data2;
  logic        s_rd_pend1, s_rd_pend2, s_init_busy;

  int n_chk = 0;
  int n_err = 0;
  int drop_b, drop_n, drop_s;

  always #5 clk = ~clk;

  regfile_mp u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(b_rd_data1), .rd_data2(b_rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_pend1(b_rd_pend1), .rd_pend2(b_rd_pend2), .init_busy(b_init_busy)
  );

  regfile_mp #(.BYPASS(0)) u_dut_n (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(n_rd_data1), .rd_data2(n_rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_pend1(n_rd_pend1), .rd_pend2(n_rd_pend2), .init_busy(n_init_busy)
  );

  regfile_mp #(.NUM_REGS(16), .DATA_W(32), .ZERO_REG(16)) u_dut_s (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(s_rd_addr1), .rd_addr2(s_rd_addr2),
    .rd_data1(s_rd_data1), .rd_data2(s_rd_data2),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .rsv_en(s_rsv_en), .rsv_addr(s_rsv_addr),
    .rd_pend1(s_rd_pend1), .rd_pend2(s_rd_pend2), .init_busy(s_init_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; rsv_addr = '0;
    wr_en = 1'b0; rsv_en = 1'b0; wr_data = '0;
    s_rd_addr1 = '0; s_rd_addr2 = '0; s_wr_addr = '0; s_rsv_addr = '0;
    s_wr_en = 1'b0; s_rsv_en = 1'b0; s_wr_data = '0;

    // Reset and first clear
    step; step;
    chk("rst_busy_b", b_init_busy, 64'd1);
    chk("rst_rd1_b",  b_rd_data1,  64'd0);
    chk("rst_pend1_b", b_rd_pend1, 64'd0);
    chk("rst_busy_s", s_init_busy, 64'd1);
    rst_n = 1'b1;
    drop_b = 0; drop_n = 0; drop_s = 0;
    for (int i = 1; i <= 40; i++) begin
      step;
      if (!b_init_busy && drop_b == 0) drop_b = i;
      if (!n_init_busy && drop_n == 0) drop_n = i;
      if (!s_init_busy && drop_s == 0) drop_s = i;
    end
    chk("clr_len_b", 64'(drop_b), 64'd32);
    chk("clr_len_n", 64'(drop_n), 64'd32);
    chk("clr_len_s", 64'(drop_s), 64'd16);
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i);
      #1;
      chk("clr_zero_b", b_rd_data1, 64'd0);
      chk("clr_zero_n", n_rd_data2, 64'd0);
    end

    // Small instance: top entry and entry 0 are ordinary registers
    s_wr_en = 1'b1; s_wr_addr = 4'd15; s_wr_data = 32'h1234; s_rd_addr1 = 4'd15;
    step;
    s_wr_en = 1'b0;
    #1 chk("s_x15", s_rd_data1, 64'h1234);
    s_wr_en = 1'b1; s_wr_addr = 4'd0; s_wr_data = 32'h55; s_rd_addr2 = 4'd0;
    step;
    s_wr_en = 1'b0;
    #1 chk("s_x0", s_rd_data2, 64'h55);
    s_rsv_en = 1'b1; s_rsv_addr = 4'd0; s_rd_addr1 = 4'd0;
    step;
    s_rsv_en = 1'b0;
    #1 chk("s_pend0", s_rd_pend1, 64'd1);

    // Write X5 with same-cycle read
    rd_addr1 = 5'd5; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEADBEEF_00000001;
    #1;
    chk("byp_same_b", b_rd_data1, 64'hDEADBEEF_00000001);
    chk("byp_same_n", n_rd_data1, 64'd0);
    step;
    wr_en = 1'b0; rd_addr2 = 5'd5;
    #1;
    chk("wr_after_b", b_rd_data1, 64'hDEADBEEF_00000001);
    chk("wr_after_n", n_rd_data1, 64'hDEADBEEF_00000001);
    chk("wr_port2_n", n_rd_data2, 64'hDEADBEEF_00000001);

    // Zero register ignores writes and reservations
    rd_addr1 = 5'd31; rd_addr2 = 5'd31;
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("zr_same1_b", b_rd_data1, 64'd0);
    chk("zr_same2_b", b_rd_data2, 64'd0);
    step;
    wr_en = 1'b0;
    #1;
    chk("zr_after_n", n_rd_data1, 64'd0);
    chk("zr_after_b", b_rd_data2, 64'd0);
    rd_addr1 = 5'd5;
    #1 chk("zr_x5_b", b_rd_data1, 64'hDEADBEEF_00000001);
    rsv_en = 1'b1; rsv_addr = 5'd31;
    step;
    rsv_en = 1'b0; rd_addr1 = 5'd31;
    #1 chk("zr_pend_b", b_rd_pend1, 64'd0);

    // Scoreboard on X7
    rsv_en = 1'b1; rsv_addr = 5'd7; rd_addr2 = 5'd7;
    #1 chk("pend_pre_b", b_rd_pend2, 64'd0);
    step;
    rsv_en = 1'b0;
    #1 chk("pend_set_b", b_rd_pend2, 64'd1);
    step;
    chk("pend_hold_b", b_rd_pend2, 64'd1);
    chk("pend_hold_n", n_rd_pend2, 64'd1);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h77;
    #1;
    chk("pend_ret_b", b_rd_pend2, 64'd0);
    chk("pend_ret_n", n_rd_pend2, 64'd1);
    step;
    wr_en = 1'b0;
    #1;
    chk("pend_clr_b", b_rd_pend2, 64'd0);
    chk("pend_clr_n", n_rd_pend2, 64'd0);
    chk("x7_data_b", b_rd_data2, 64'h77);
    rsv_en = 1'b1; rsv_addr = 5'd7; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h88;
    step;
    rsv_en = 1'b0; wr_en = 1'b0;
    #1;
    chk("pend_win_b", b_rd_pend2, 64'd1);
    chk("pend_win_n", n_rd_pend2, 64'd1);
    chk("x7_data2_n", n_rd_data2, 64'h88);

    // Reset mid-clear with writes and reservations held active
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hAAAA;
    rsv_en = 1'b1; rsv_addr = 5'd3; rd_addr1 = 5'd3; rd_addr2 = 5'd7;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    chk("rst2_busy_b", b_init_busy, 64'd1);
    for (int i = 0; i < 10; i++) step;
    chk("clr_rd_b",   b_rd_data1, 64'd0);
    chk("clr_pend_b", b_rd_pend1, 64'd0);
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    drop_b = 0; drop_n = 0; drop_s = 0;
    for (int i = 1; i <= 40; i++) begin
      step;
      if (!b_init_busy && drop_b == 0) begin
        drop_b = i;
        wr_en = 1'b0; rsv_en = 1'b0;
      end
      if (!n_init_busy && drop_n == 0) drop_n = i;
      if (!s_init_busy && drop_s == 0) drop_s = i;
    end
    chk("reclr_len_b", 64'(drop_b), 64'd32);
    chk("reclr_len_n", 64'(drop_n), 64'd32);
    chk("reclr_len_s", 64'(drop_s), 64'd16);
    #1;
    chk("reclr_x3_b", b_rd_data1, 64'd0);
    chk("reclr_x3_n", n_rd_data1, 64'd0);
    chk("reclr_p3_b", b_rd_pend1, 64'd0);
    chk("reclr_x7_b", b_rd_data2, 64'd0);
    chk("reclr_p7_b", b_rd_pend2, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
